// File: rtl/seq_match_reporter_if.sv
// Report handshake between seq_match_reporter and its consumer.
//   rpt_valid : head of the timestamp FIFO holds a report
//   rpt_ready : consumer accepts the head at the next rising edge
//   rpt_ts    : timestamp at the FIFO head, 0 when empty
// Modports: master (reporter side), slave (consumer side).
interface seq_match_reporter_if #(
    parameter int TS_W = 16
);
    logic            rpt_valid;
    logic            rpt_ready;
    logic [TS_W-1:0] rpt_ts;

    modport master (output rpt_valid, output rpt_ts, input rpt_ready);
    modport slave  (input rpt_valid, input rpt_ts, output rpt_ready);
endinterface

// File: rtl/seq_match_reporter.sv
// seq_match_reporter
// Timestamps each qualified match pulse against a free-running cycle counter
// and queues the timestamps in a show-ahead FIFO. The FIFO is drained over
// a valid/ready interface. Also keeps a saturating match count and a sticky
// overflow flag.
//
// Optional feature: define MATCH_HOLDOFF_EN to qualify only matches spaced
// at least HOLDOFF cycles from the previous qualified one.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   z_in       : match pulse from the detector
//   clr_ovf    : clears the sticky overflow flag (a same-cycle drop wins)
//   rpt        : report handshake (master modport)
//   match_cnt  : saturating count of qualified matches
//   fifo_level : number of occupied FIFO entries
//   ovf        : sticky, a qualified match was dropped on a full FIFO
module seq_match_reporter #(
    parameter int TS_W    = 16,
    parameter int CNT_W   = 8,
    parameter int DEPTH   = 4,
    parameter int HOLDOFF = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     z_in,
    input  logic                     clr_ovf,
    seq_match_reporter_if.master     rpt,
    output logic [CNT_W-1:0]         match_cnt,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     ovf
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HOLDOFF < 1) begin : g_bad_param
        $error("seq_match_reporter: DEPTH must be a power of two >= 2, HOLDOFF >= 1");
    end

    logic [TS_W-1:0]  ts;
    logic [TS_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [LVL_W-1:0] level_nxt;
    logic [TS_W-1:0]  head_nxt;
    logic             qual;
    logic             pop;
    logic             push_ok;

`ifdef MATCH_HOLDOFF_EN
    localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    logic [HO_W-1:0] holdoff_cnt;

    // Only qualified pulses reload the window; ignored pulses leave it running.
    assign qual = z_in && (holdoff_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            holdoff_cnt <= '0;
        end else if (qual) begin
            holdoff_cnt <= HO_W'(HOLDOFF - 1);
        end else if (holdoff_cnt != '0) begin
            holdoff_cnt <= holdoff_cnt - 1'b1;
        end
    end
`else
    assign qual = z_in;
`endif

    assign pop     = rpt.rpt_valid && rpt.rpt_ready;
    // A full FIFO still accepts the push when the head leaves in the same cycle.
    assign push_ok = qual && ((fifo_level != FULL_LVL) || pop);

    always_comb begin
        level_nxt  = fifo_level;
        rd_ptr_nxt = rd_ptr;
        head_nxt   = '0;
        if (push_ok && !pop) begin
            level_nxt = fifo_level + 1'b1;
        end else if (!push_ok && pop) begin
            level_nxt = fifo_level - 1'b1;
        end
        if (pop) begin
            rd_ptr_nxt = rd_ptr + 1'b1;
        end
        // The head is registered, so it must be computed one cycle ahead;
        // when the new push becomes the only entry it bypasses the memory.
        if (level_nxt != '0) begin
            if (push_ok && ((fifo_level == '0) || (pop && fifo_level == LVL_W'(1)))) begin
                head_nxt = ts;
            end else begin
                head_nxt = mem[rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= ts;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts            <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_level    <= '0;
            rpt.rpt_valid <= 1'b0;
            rpt.rpt_ts    <= '0;
            match_cnt     <= '0;
            ovf           <= 1'b0;
        end else begin
            ts            <= ts + 1'b1;
            rd_ptr        <= rd_ptr_nxt;
            fifo_level    <= level_nxt;
            rpt.rpt_valid <= (level_nxt != '0);
            rpt.rpt_ts    <= head_nxt;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (qual && (match_cnt != '1)) begin
                match_cnt <= match_cnt + 1'b1;
            end
            if (qual && !push_ok) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seq_match_reporter.sv
module tb_seq_match_reporter;
    localparam int TS_W  = 16;
    localparam int CNT_W = 3;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    logic z_in;
    logic clr_ovf;
    logic [CNT_W-1:0] match_cnt;
    logic [2:0] fifo_level;
    logic ovf;

    int n_pass;
    int n_total;

    seq_match_reporter_if #(.TS_W(TS_W)) rpt_bus ();

    seq_match_reporter #(
        .TS_W(TS_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .HOLDOFF(5)
    ) dut (
        .clk(clk), .rst(rst), .z_in(z_in), .clr_ovf(clr_ovf),
        .rpt(rpt_bus.master),
        .match_cnt(match_cnt), .fifo_level(fifo_level), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0 (first cycle with rst low).
    task automatic do_reset();
        rst = 1'b1; z_in = 1'b0; clr_ovf = 1'b0; rpt_bus.rpt_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (rpt_bus.rpt_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", rpt_bus.rpt_valid); else n_pass++;
        n_total++; if (rpt_bus.rpt_ts !== 16'd0) $display("FAIL reset_ts got %0d want 0", rpt_bus.rpt_ts); else n_pass++;
        n_total++; if (fifo_level !== 3'd0) $display("FAIL reset_level got %0d want 0", fifo_level); else n_pass++;
        n_total++; if (match_cnt !== 3'd0) $display("FAIL reset_cnt got %0d want 0", match_cnt); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %0b want 0", ovf); else n_pass++;
    endtask

    task automatic test_basic();
        logic exp_v;
        do_reset();
        rpt_bus.rpt_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            z_in = (c == 3 || c == 10);
            step();
            z_in = 1'b0;
            exp_v = (c == 3 || c == 10);
            n_total++;
            if (rpt_bus.rpt_valid !== exp_v) $display("FAIL basic_valid cyc %0d got %0b want %0b", c + 1, rpt_bus.rpt_valid, exp_v);
            else n_pass++;
            if (exp_v) begin
                n_total++;
                if (rpt_bus.rpt_ts !== TS_W'(c)) $display("FAIL basic_ts cyc %0d got %0d want %0d", c + 1, rpt_bus.rpt_ts, c);
                else n_pass++;
            end
        end
        n_total++; if (match_cnt !== 3'd2) $display("FAIL basic_cnt got %0d want 2", match_cnt); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL basic_ovf got %0b want 0", ovf); else n_pass++;
    endtask

    task automatic test_overflow();
        int pushes;
        int exp_lvl;
        do_reset();
        pushes = 0;
        for (int c = 0; c < 25; c++) begin
            z_in = (c % 6 == 0);
            if (c % 6 == 0) pushes++;
            step();
            z_in = 1'b0;
            exp_lvl = (pushes > 4) ? 4 : pushes;
            n_total++;
            if (fifo_level !== 3'(exp_lvl)) $display("FAIL ovf_level cyc %0d got %0d want %0d", c + 1, fifo_level, exp_lvl);
            else n_pass++;
            n_total++;
            if (ovf !== (c >= 24)) $display("FAIL ovf_flag cyc %0d got %0b want %0b", c + 1, ovf, (c >= 24));
            else n_pass++;
        end
        n_total++; if (match_cnt !== 3'd5) $display("FAIL ovf_cnt got %0d want 5", match_cnt); else n_pass++;
        rpt_bus.rpt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (rpt_bus.rpt_valid !== 1'b1 || rpt_bus.rpt_ts !== TS_W'(i * 6))
                $display("FAIL ovf_drain %0d got v=%0b ts=%0d want v=1 ts=%0d", i, rpt_bus.rpt_valid, rpt_bus.rpt_ts, i * 6);
            else n_pass++;
            step();
        end
        n_total++;
        if (rpt_bus.rpt_valid !== 1'b0 || rpt_bus.rpt_ts !== 16'd0)
            $display("FAIL ovf_empty got v=%0b ts=%0d want v=0 ts=0", rpt_bus.rpt_valid, rpt_bus.rpt_ts);
        else n_pass++;
    endtask

    task automatic test_full_push_pop();
        int exp_ts [4];
        exp_ts[0] = 5; exp_ts[1] = 10; exp_ts[2] = 15; exp_ts[3] = 20;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            z_in = (c % 5 == 0);
            step();
            z_in = 1'b0;
        end
        n_total++; if (fifo_level !== 3'd4) $display("FAIL full_level_pre got %0d want 4", fifo_level); else n_pass++;
        z_in = 1'b1;
        rpt_bus.rpt_ready = 1'b1;
        step();
        z_in = 1'b0;
        n_total++; if (fifo_level !== 3'd4) $display("FAIL full_level_post got %0d want 4", fifo_level); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL full_ovf got %0b want 0", ovf); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (rpt_bus.rpt_valid !== 1'b1 || rpt_bus.rpt_ts !== TS_W'(exp_ts[i]))
                $display("FAIL full_drain %0d got v=%0b ts=%0d want v=1 ts=%0d", i, rpt_bus.rpt_valid, rpt_bus.rpt_ts, exp_ts[i]);
            else n_pass++;
            step();
        end
        n_total++; if (rpt_bus.rpt_valid !== 1'b0) $display("FAIL full_empty got %0b want 0", rpt_bus.rpt_valid); else n_pass++;
    endtask

    task automatic test_holdoff();
        logic [15:0] zpat;
        logic [15:0] qpat;
        int exp_cnt;
        zpat = '0;
        zpat[2] = 1'b1; zpat[4] = 1'b1; zpat[6] = 1'b1; zpat[7] = 1'b1; zpat[12] = 1'b1;
`ifdef MATCH_HOLDOFF_EN
        qpat = '0;
        qpat[2] = 1'b1; qpat[7] = 1'b1; qpat[12] = 1'b1;
        exp_cnt = 3;
`else
        qpat = zpat;
        exp_cnt = 5;
`endif
        do_reset();
        rpt_bus.rpt_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            z_in = zpat[c];
            step();
            z_in = 1'b0;
            n_total++;
            if (rpt_bus.rpt_valid !== qpat[c]) $display("FAIL hold_valid cyc %0d got %0b want %0b", c + 1, rpt_bus.rpt_valid, qpat[c]);
            else n_pass++;
            if (qpat[c]) begin
                n_total++;
                if (rpt_bus.rpt_ts !== TS_W'(c)) $display("FAIL hold_ts cyc %0d got %0d want %0d", c + 1, rpt_bus.rpt_ts, c);
                else n_pass++;
            end
        end
        n_total++; if (match_cnt !== 3'(exp_cnt)) $display("FAIL hold_cnt got %0d want %0d", match_cnt, exp_cnt); else n_pass++;
    endtask

    task automatic test_saturate_clear();
        do_reset();
        for (int c = 0; c < 45; c++) begin
            z_in = (c % 5 == 0);
            step();
            z_in = 1'b0;
        end
        n_total++; if (match_cnt !== 3'd7) $display("FAIL sat_cnt got %0d want 7", match_cnt); else n_pass++;
        n_total++; if (ovf !== 1'b1) $display("FAIL sat_ovf got %0b want 1", ovf); else n_pass++;
        n_total++; if (fifo_level !== 3'd4) $display("FAIL sat_level got %0d want 4", fifo_level); else n_pass++;
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        n_total++; if (ovf !== 1'b0) $display("FAIL clr_ovf got %0b want 0", ovf); else n_pass++;
        clr_ovf = 1'b1;
        z_in = 1'b1;
        step();
        clr_ovf = 1'b0;
        z_in = 1'b0;
        n_total++; if (ovf !== 1'b1) $display("FAIL clr_vs_drop got %0b want 1", ovf); else n_pass++;
        n_total++; if (match_cnt !== 3'd7) $display("FAIL sat_hold got %0d want 7", match_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            z_in = (c % 5 == 0);
            step();
            z_in = 1'b0;
        end
        n_total++; if (fifo_level !== 3'd3) $display("FAIL mid_level_pre got %0d want 3", fifo_level); else n_pass++;
        rst = 1'b1;
        z_in = 1'b1;
        step();
        rst = 1'b0;
        z_in = 1'b0;
        n_total++;
        if (rpt_bus.rpt_valid !== 1'b0 || rpt_bus.rpt_ts !== 16'd0 || fifo_level !== 3'd0 || match_cnt !== 3'd0 || ovf !== 1'b0)
            $display("FAIL mid_reset got v=%0b ts=%0d lvl=%0d cnt=%0d ovf=%0b want all 0",
                     rpt_bus.rpt_valid, rpt_bus.rpt_ts, fifo_level, match_cnt, ovf);
        else n_pass++;
        z_in = 1'b1;
        step();
        z_in = 1'b0;
        n_total++;
        if (rpt_bus.rpt_valid !== 1'b1 || rpt_bus.rpt_ts !== 16'd0 || match_cnt !== 3'd1)
            $display("FAIL mid_first got v=%0b ts=%0d cnt=%0d want v=1 ts=0 cnt=1", rpt_bus.rpt_valid, rpt_bus.rpt_ts, match_cnt);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b1; z_in = 1'b0; clr_ovf = 1'b0; rpt_bus.rpt_ready = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_holdoff();
        test_saturate_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
